// File: rtl/rfsoc_serial_pkg.sv
// Shared types and helpers for the serial configuration-chain blocks.
package rfsoc_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        LATCH
    } tx_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_word_tx_if.sv
// Word handshake plus serial link signals of the word transmitter.
interface serial_word_tx_if #(
    parameter int unsigned WIDTH = 32
);

    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic             sclk;
    logic             sdata;
    logic             latch;
    logic             busy;
    logic             done;

    // Word producer side.
    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  sclk,
        input  sdata,
        input  latch,
        input  busy,
        input  done
    );

    // Transmitter side.
    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output sclk,
        output sdata,
        output latch,
        output busy,
        output done
    );

endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial transmitter: shifts one word out on sclk/sdata at clk/(2*CLK_DIV),
// then holds latch high for LATCH_CYCLES and pulses done.
module serial_word_tx
    import rfsoc_serial_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned LATCH_CYCLES = 2,
    parameter int unsigned LSB_FIRST    = 1
) (
    input  logic             clk,
    input  logic             reset,
    serial_word_tx_if.slave  bus
);

    localparam int unsigned HALF_W = cnt_w(CLK_DIV);
    localparam int unsigned BIT_W  = cnt_w(WIDTH);
    localparam int unsigned LAT_W  = cnt_w(LATCH_CYCLES + 1);

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATCH_CYCLES - 1);

    if (WIDTH < 1) begin : g_bad_width
        $error("serial_word_tx: WIDTH must be >= 1");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("serial_word_tx: CLK_DIV must be >= 2");
    end
    if (LATCH_CYCLES < 1) begin : g_bad_latch
        $error("serial_word_tx: LATCH_CYCLES must be >= 1");
    end

    tx_state_t         state_q, state_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic              sclk_q, sclk_d;
    logic              sdata_q, sdata_d;
    logic              latch_q, latch_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  sr_shift;
    logic              first_bit;
    logic              next_bit;

    // Shift direction picks which end of the register feeds sdata.
    assign sr_shift  = (LSB_FIRST != 0) ? (sr_q >> 1) : (sr_q << 1);
    assign next_bit  = (LSB_FIRST != 0) ? sr_shift[0] : sr_shift[WIDTH-1];
    assign first_bit = (LSB_FIRST != 0) ? bus.s_data[0] : bus.s_data[WIDTH-1];

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            lat_cnt_q  <= '0;
            sr_q       <= '0;
            sclk_q     <= 1'b0;
            sdata_q    <= 1'b0;
            latch_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            sr_q       <= sr_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
            latch_q    <= latch_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; sdata only moves on accept and on the sclk falling edge.
    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        sr_d       = sr_q;
        sclk_d     = sclk_q;
        sdata_d    = sdata_q;
        latch_d    = latch_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.s_valid) begin
                    state_d    = LOW;
                    sr_d       = bus.s_data;
                    sdata_d    = first_bit;
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                    sclk_d     = 1'b0;
                    latch_d    = 1'b0;
                end
            end
            LOW: begin
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    sclk_d     = 1'b1;
                    state_d    = HIGH;
                end else begin
                    half_cnt_d = half_cnt_q + HALF_W'(1);
                end
            end
            HIGH: begin
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    sclk_d     = 1'b0;
                    if (bit_cnt_q == BIT_LAST) begin
                        latch_d   = 1'b1;
                        lat_cnt_d = '0;
                        state_d   = LATCH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        sr_d      = sr_shift;
                        sdata_d   = next_bit;
                        state_d   = LOW;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + HALF_W'(1);
                end
            end
            LATCH: begin
                if (lat_cnt_q == LAT_LAST) begin
                    lat_cnt_d = '0;
                    latch_d   = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.s_ready = (state_q == IDLE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.sclk    = sclk_q;
    assign bus.sdata   = sdata_q;
    assign bus.latch   = latch_q;
    assign bus.done    = done_q;

endmodule
